// File: rtl/arr_pkg.sv
// Shared constants, FSM encoding and width helpers for the activation skew feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arr_pkg;

    localparam int ARR_ROWS    = 16;
    localparam int ARR_DW      = 8;
    localparam int ARR_MAX_LEN = 144;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Width of a per-row length register: must hold 0..max_len inclusive.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Width of the drain cycle counter: t runs up to (rows-1)+max_len-1.
    function automatic int t_width(input int max_len, input int rows);
        return $clog2(max_len + rows);
    endfunction

endpackage

// File: rtl/act_row_buf.sv
// One PE row's window store: byte write port, length register, read at index (t - ROW).
// Latency: write visible next cycle; read is a decode of registered t/len/storage (same cycle).
// Backpressure: none; the parent only writes while filling and only reads while draining.
module act_row_buf
    import arr_pkg::*;
#(
    parameter int DW      = ARR_DW,
    parameter int MAX_LEN = ARR_MAX_LEN,
    parameter int LW      = len_width(ARR_MAX_LEN),
    parameter int TW      = t_width(ARR_MAX_LEN, ARR_ROWS),
    parameter int ROW     = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [LW-1:0] i_wr_idx,
    input  logic [DW-1:0] i_wr_dat,
    input  logic          i_len_set,
    input  logic [LW-1:0] i_len_val,
    input  logic          i_clr,
    input  logic          i_drain,
    input  logic [TW-1:0] i_t,
    output logic          o_vld,
    output logic [DW-1:0] o_dat,
    output logic          o_end
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [DW-1:0] r_mem [MAX_LEN];
    logic [LW-1:0] r_len;
    int            w_rel;
    logic          w_in_win;
    logic [IW-1:0] w_rd_idx;

    // Window storage; no reset needed since reads are always qualified by r_len.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[IW'(i_wr_idx)] <= i_wr_dat;
        end
    end

    // Row length: zero means the row was never closed and stays silent in the drain.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_len <= '0;
        end else if (i_len_set) begin
            r_len <= i_len_val;
        end
    end

    // Skewed read window and "this row is finished after the current cycle" flag.
    always_comb begin
        w_rel    = int'(i_t) - ROW;
        w_in_win = i_drain && (w_rel >= 0) && (w_rel < int'(r_len));
        w_rd_idx = IW'(w_rel);
        o_end    = (r_len == '0) || ((int'(i_t) + 1) >= (ROW + int'(r_len)));
    end

    assign o_vld = w_in_win;
    assign o_dat = w_in_win ? r_mem[w_rd_idx] : '0;

endmodule

// File: rtl/act_skew_feeder.sv
// Buffers up to ROWS activation windows, then drains them into the array with a one-cycle-per-row skew.
// Latency: closing transfer/flush at cycle N -> fire and first drain beat at N+1; done the cycle after the last beat.
// Backpressure: in_ready high only while filling; the drain never stalls.
module act_skew_feeder
    import arr_pkg::*;
#(
    parameter int ROWS    = ARR_ROWS,
    parameter int DW      = ARR_DW,
    parameter int MAX_LEN = ARR_MAX_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DW-1:0]      in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    input  logic               flush,
    output logic [ROWS*DW-1:0] act_out,
    output logic [ROWS-1:0]    act_valid,
    output logic               fire,
    output logic               done,
    output logic               busy,
    output logic               ovf_err
);

    localparam int LW = len_width(MAX_LEN);
    localparam int TW = t_width(MAX_LEN, ROWS);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t        r_state;
    logic [RW-1:0] r_wr_row;
    logic [LW-1:0] r_idx;
    logic [TW-1:0] r_t;
    logic          r_fire;
    logic          r_done;
    logic          r_ovf;

    logic          w_xfer;
    logic          w_full;
    logic [LW-1:0] w_idx_inc;
    logic [LW-1:0] w_idx_after;
    logic          w_close_last;
    logic          w_last_row;
    logic          w_flush_go;
    logic          w_go;
    logic          w_len_set;
    logic [LW-1:0] w_len_val;
    logic          w_drain;
    logic          w_drain_end;
    logic          w_clr;
    logic [ROWS-1:0] w_row_end;

    assign in_ready = (r_state == FILL);
    assign busy     = (r_state == DRAIN);
    assign fire     = r_fire;
    assign done     = r_done;
    assign ovf_err  = r_ovf;
    assign w_drain  = (r_state == DRAIN);

    // Fill-side decode: bytes past MAX_LEN are dropped but in_last still closes the row.
    always_comb begin
        w_xfer       = in_valid && in_ready;
        w_full       = (r_idx == LW'(MAX_LEN));
        w_idx_inc    = w_full ? r_idx : (r_idx + LW'(1));
        w_close_last = w_xfer && in_last;
        w_idx_after  = w_xfer ? (in_last ? '0 : w_idx_inc) : r_idx;
        w_last_row   = (r_wr_row == RW'(ROWS - 1));
        // flush counts whatever is held after this cycle's transfer; an empty buffer ignores it
        w_flush_go   = flush && in_ready &&
                       (w_close_last || (r_wr_row != '0) || (w_idx_after != '0));
        w_go         = (w_close_last && w_last_row) || w_flush_go;
        w_len_set    = w_close_last || (w_flush_go && (w_idx_after != '0));
        w_len_val    = w_xfer ? w_idx_inc : r_idx;
        w_drain_end  = &w_row_end;
        w_clr        = w_drain && w_drain_end;
    end

    // Batch FSM: fill pointers, drain counter and the fire/done/overflow flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= FILL;
            r_wr_row <= '0;
            r_idx    <= '0;
            r_t      <= '0;
            r_fire   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_fire <= 1'b0;
            r_done <= 1'b0;
            if (w_xfer && w_full) begin
                r_ovf <= 1'b1;
            end
            case (r_state)
                FILL: begin
                    r_idx <= w_idx_after;
                    if (w_close_last) begin
                        r_wr_row <= r_wr_row + RW'(1);
                    end
                    if (w_go) begin
                        r_state <= DRAIN;
                        r_t     <= '0;
                        r_fire  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_drain_end) begin
                        r_state  <= FILL;
                        r_done   <= 1'b1;
                        r_wr_row <= '0;
                        r_idx    <= '0;
                        r_t      <= '0;
                    end else begin
                        r_t <= r_t + TW'(1);
                    end
                end
            endcase
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic w_sel;
        assign w_sel = (r_wr_row == RW'(r));

        act_row_buf #(
            .DW      (DW),
            .MAX_LEN (MAX_LEN),
            .LW      (LW),
            .TW      (TW),
            .ROW     (r)
        ) u_row (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_xfer && !w_full && w_sel),
            .i_wr_idx  (r_idx),
            .i_wr_dat  (in_data),
            .i_len_set (w_len_set && w_sel),
            .i_len_val (w_len_val),
            .i_clr     (w_clr),
            .i_drain   (w_drain),
            .i_t       (r_t),
            .o_vld     (act_valid[r]),
            .o_dat     (act_out[r*DW +: DW]),
            .o_end     (w_row_end[r])
        );
    end

endmodule
